// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned OVERSAMPLE_DEF = 16;

   localparam int unsigned PAR_EVEN = 0;
   localparam int unsigned PAR_ODD  = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter; flags the tick that closes the current bit period.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic clk,
   input  logic areset,
   input  logic clear,
   input  logic s_tick,
   output logic bit_end_c
);

   localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   logic [TW-1:0] cnt;

   assign bit_end_c = s_tick && (cnt == TW'(OVERSAMPLE - 1));

   // Count ticks within a bit, wrapping on the bit-ending tick.
   always_ff @(posedge clk) begin
      if (areset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (s_tick) begin
         cnt <= bit_end_c ? '0 : cnt + TW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, LSB-first data, optional parity, stop bits.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = PAR_EVEN,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 s_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int unsigned BCW     = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

   tx_state_t            state, state_nxt;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
   logic                 parity_q, parity_nxt;
   logic                 bit_end_c;
   logic                 accept_c;
   logic                 tx_d, ready_d, busy_d, done_d;

   assign accept_c = tx_valid && tx_ready;

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk       (clk),
      .areset    (areset),
      .clear     (state == IDLE),
      .s_tick    (s_tick),
      .bit_end_c (bit_end_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state sequencing of the frame.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (accept_c) state_nxt = START;
         START:  if (bit_end_c) state_nxt = DATA;
         DATA: begin
            if (bit_end_c && (bit_cnt == BCW'(DATA_BITS - 1))) begin
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: if (bit_end_c) state_nxt = STOP;
         STOP: begin
            if (bit_end_c && (bit_cnt == BCW'(STOP_BITS - 1))) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register, bit counter and parity capture.
   always_comb begin
      shift_nxt   = shift_q;
      bit_cnt_nxt = bit_cnt;
      parity_nxt  = parity_q;
      case (state)
         IDLE: begin
            bit_cnt_nxt = '0;
            if (accept_c) begin
               shift_nxt  = tx_data;
               parity_nxt = (^tx_data) ^ (PARITY_ODD == PAR_ODD);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               shift_nxt   = shift_q >> 1;
               bit_cnt_nxt = (state_nxt == DATA) ? bit_cnt + BCW'(1) : '0;
            end
         end
         STOP: begin
            if (bit_end_c) begin
               bit_cnt_nxt = (state_nxt == STOP) ? bit_cnt + BCW'(1) : '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (areset) begin
         shift_q  <= '0;
         bit_cnt  <= '0;
         parity_q <= 1'b0;
      end else begin
         shift_q  <= shift_nxt;
         bit_cnt  <= bit_cnt_nxt;
         parity_q <= parity_nxt;
      end
   end

   // Output decode from the upcoming state so tx tracks state changes without lag.
   always_comb begin
      tx_d    = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = (state == STOP) && (state_nxt == IDLE);
      case (state_nxt)
         IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_nxt[0];
         PARITY:  tx_d = parity_q;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (areset) begin
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx       <= tx_d;
         tx_ready <= ready_d;
         busy     <= busy_d;
         tx_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl across four frame formats sharing one tick source.
module tb_uart_tx_ctrl;

   logic       clk;
   logic       areset;
   logic       s_tick;
   logic [7:0] tx_data;
   logic [3:0] tx_valid_v;
   logic [3:0] tx_ready_v;
   logic [3:0] tx_v;
   logic [3:0] busy_v;
   logic [3:0] done_v;

   logic       tick_en;
   int         ph;
   int         done_cnt [4];
   int         total;
   int         bad;

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
   uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
      .clk(clk), .areset(areset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
      .tx_ready(tx_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

   uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
      .clk(clk), .areset(areset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid_v[1]),
      .tx_ready(tx_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

   uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_8o1 (
      .clk(clk), .areset(areset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid_v[2]),
      .tx_ready(tx_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

   uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
      .clk(clk), .areset(areset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid_v[3]),
      .tx_ready(tx_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One tick every 4 clk; the phase keeps running while ticks are gated off.
   initial begin
      s_tick = 1'b0;
      ph     = 0;
      forever begin
         @(posedge clk);
         #1;
         s_tick = tick_en && (ph == 3);
         ph     = (ph + 1) % 4;
      end
   end

   // Count tx_done pulses per instance.
   initial begin
      for (int k = 0; k < 4; k++) done_cnt[k] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) if (done_v[k] === 1'b1) done_cnt[k]++;
      end
   end

   // Present one word to instance k; returns on the negedge after acceptance.
   task automatic send(input int k, input logic [7:0] d);
      @(negedge clk);
      tx_data       = d;
      tx_valid_v[k] = 1'b1;
      total++;
      if (tx_ready_v[k] !== 1'b1) begin
         bad++;
         $display("FAIL send_ready[%0d]: got %b want 1", k, tx_ready_v[k]);
      end
      @(negedge clk);
      tx_valid_v[k] = 1'b0;
   endtask

   // Check a whole frame mid-bit; entered on the negedge after acceptance,
   // returns on the negedge of the tx_done cycle.
   task automatic check_frame(input int k, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input int nstop, input int stall_idx,
                              input string nm);
      logic exp_b [0:15];
      int   nb;
      int   d0;
      int   n;
      nb = 0;
      exp_b[nb++] = 1'b0;
      for (int i = 0; i < 8; i++) exp_b[nb++] = d[i];
      if (par_en) exp_b[nb++] = par_bit;
      for (int i = 0; i < nstop; i++) exp_b[nb++] = 1'b1;
      d0 = done_cnt[k];

      total++;
      if (tx_v[k] !== 1'b0) begin
         bad++;
         $display("FAIL %s start_latency: tx got %b want 0", nm, tx_v[k]);
      end
      total++;
      if (tx_ready_v[k] !== 1'b0 || busy_v[k] !== 1'b1) begin
         bad++;
         $display("FAIL %s accept_flags: ready/busy got %b/%b want 0/1", nm, tx_ready_v[k], busy_v[k]);
      end

      repeat (31) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         if (i > 0) repeat (64) @(negedge clk);
         total++;
         if (tx_v[k] !== exp_b[i]) begin
            bad++;
            $display("FAIL %s bit%0d: tx got %b want %b", nm, i, tx_v[k], exp_b[i]);
         end
         total++;
         if (tx_ready_v[k] !== 1'b0 || busy_v[k] !== 1'b1 || done_cnt[k] != d0) begin
            bad++;
            $display("FAIL %s flags_bit%0d: ready/busy/dones got %b/%b/%0d want 0/1/%0d",
                     nm, i, tx_ready_v[k], busy_v[k], done_cnt[k] - d0, 0);
         end
         if (i == stall_idx) begin
            tick_en = 1'b0;
            repeat (100) begin
               @(negedge clk);
               total++;
               if (tx_v[k] !== exp_b[i] || busy_v[k] !== 1'b1) begin
                  bad++;
                  $display("FAIL %s stall: tx/busy got %b/%b want %b/1", nm, tx_v[k], busy_v[k], exp_b[i]);
               end
            end
            tick_en = 1'b1;
         end
      end

      n = 0;
      while (done_v[k] !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_v[k] !== 1'b1) begin
         bad++;
         $display("FAIL %s done_timeout: tx_done got %b want 1", nm, done_v[k]);
      end
      total++;
      if (tx_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_cnt[k] != d0 + 1) begin
         bad++;
         $display("FAIL %s end_state: tx/busy/dones got %b/%b/%0d want 1/0/1",
                  nm, tx_v[k], busy_v[k], done_cnt[k] - d0);
      end
   endtask

   // Idle cycle after a frame: ready back, done pulse gone.
   task automatic check_idle_after(input int k, input string nm);
      @(negedge clk);
      total++;
      if (tx_ready_v[k] !== 1'b1 || done_v[k] !== 1'b0 || tx_v[k] !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_after: ready/done/tx got %b/%b/%b want 1/0/1",
                  nm, tx_ready_v[k], done_v[k], tx_v[k]);
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (tx_v !== 4'hF || tx_ready_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
         bad++;
         $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b want 1111/1111/0000/0000",
                  tx_v, tx_ready_v, busy_v, done_v);
      end
      // Handshake during reset must be dropped.
      tx_data       = 8'h3C;
      tx_valid_v[0] = 1'b1;
      @(negedge clk);
      areset        = 1'b0;
      tx_valid_v[0] = 1'b0;
      total++;
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || tx_ready_v[0] !== 1'b1) begin
         bad++;
         $display("FAIL reset_wins: tx/busy/ready got %b/%b/%b want 1/0/1", tx_v[0], busy_v[0], tx_ready_v[0]);
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy_v[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_wins_later: busy got %b want 0", busy_v[0]);
      end
   endtask

   task automatic test_8n1();
      send(0, 8'hA5);
      check_frame(0, 8'hA5, 1'b0, 1'b0, 1, -1, "8n1_a5");
      check_idle_after(0, "8n1_a5");
   endtask

   task automatic test_parity();
      send(1, 8'h07);
      check_frame(1, 8'h07, 1'b1, 1'b1, 1, -1, "even_07");
      check_idle_after(1, "even_07");
      send(2, 8'h07);
      check_frame(2, 8'h07, 1'b1, 1'b0, 1, -1, "odd_07");
      check_idle_after(2, "odd_07");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      tx_data       = 8'h11;
      tx_valid_v[0] = 1'b1;
      @(negedge clk);
      tx_data = 8'h22;
      check_frame(0, 8'h11, 1'b0, 1'b0, 1, -1, "b2b_11");
      @(negedge clk);
      tx_valid_v[0] = 1'b0;
      check_frame(0, 8'h22, 1'b0, 1'b0, 1, -1, "b2b_22");
      check_idle_after(0, "b2b_22");
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      d0 = done_cnt[0];
      send(0, 8'h5A);
      repeat (31 + 64 * 4) @(negedge clk);
      total++;
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
         bad++;
         $display("FAIL midreset_bit3: tx/busy got %b/%b want 1/1", tx_v[0], busy_v[0]);
      end
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      total++;
      if (tx_v[0] !== 1'b1 || tx_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
         bad++;
         $display("FAIL midreset_after: tx/ready/busy got %b/%b/%b want 1/1/0",
                  tx_v[0], tx_ready_v[0], busy_v[0]);
      end
      repeat (700) @(negedge clk);
      total++;
      if (done_cnt[0] != d0 || tx_v[0] !== 1'b1 || tx_ready_v[0] !== 1'b1) begin
         bad++;
         $display("FAIL midreset_no_done: dones/tx/ready got %0d/%b/%b want 0/1/1",
                  done_cnt[0] - d0, tx_v[0], tx_ready_v[0]);
      end
      send(0, 8'hFF);
      check_frame(0, 8'hFF, 1'b0, 1'b0, 1, -1, "after_reset_ff");
      check_idle_after(0, "after_reset_ff");
   endtask

   task automatic test_two_stop();
      send(3, 8'h00);
      check_frame(3, 8'h00, 1'b0, 1'b0, 2, -1, "8n2_00");
      check_idle_after(3, "8n2_00");
   endtask

   task automatic test_stall();
      send(0, 8'hC3);
      check_frame(0, 8'hC3, 1'b0, 1'b0, 1, 3, "stall_c3");
      check_idle_after(0, "stall_c3");
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      tick_en    = 1'b1;
      areset     = 1'b1;
      tx_data    = 8'h00;
      tx_valid_v = 4'h0;
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_two_stop();
      test_stall();
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller driven by the 16x oversample tick from the baud rate generator. Accepts a data word over a valid/ready handshake and sequences start, data (LSB first), optional parity and stop bits onto the serial line. Each bit is held for OVERSAMPLE ticks. Sits between the host-side TX interface and the tx pin; the baud generator is instantiated alongside it, and its Done output drives s_tick.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = parity bit inserted after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits per frame (1 or 2)
OVERSAMPLE, 16, s_tick pulses per bit period

Ports:
clk  input  1  system clock
areset  input  1  synchronous, active-high reset
s_tick  input  1  one-clk pulse, OVERSAMPLE per bit period (baud generator Done)
tx_data  input  DATA_BITS  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller can accept a word
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress
tx_done  output  1  one-clk pulse at end of last stop bit

Behaviour:
- Reset (areset=1 at posedge clk): state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, tick and bit counters=0, shift register=0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, tx_ready=1, busy=0.
  - When tx_valid & tx_ready: capture tx_data into the shift register, clear the tick counter, compute the parity bit, and enter START.
  - tx drives 0 on the next clk edge (latency 1 clk from acceptance).
- tx_ready=1 only in IDLE. A word presented during a frame is held off until IDLE.
- Minimum gap between frames is one clk in IDLE after tx_done.
- Tick counter: 0..OVERSAMPLE-1, increments only on s_tick. A state's bit ends on the s_tick where count==OVERSAMPLE-1; the counter then wraps to 0 and the next bit starts.
- With s_tick held low, all states stall and tx is unchanged.
- START: tx=0 for one bit period. The first period may be up to one tick short, because the tick phase is not aligned to acceptance. This is accepted.
- DATA: tx=shift[0]; shift right at each bit end. The bit counter runs 0..DATA_BITS-1; after the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the captured data, inverted when PARITY_ODD.
- STOP: tx=1 for STOP_BITS bit periods; the bit counter is reused.
  - At the end of the final stop bit: tx_done=1 for exactly one clk, state=IDLE.
- busy=1 in all non-IDLE states.
- tx_valid deasserting mid-frame has no effect on the frame in progress.
- tx_data changes after acceptance are ignored.
- Reset mid-frame: the frame is aborted and no tx_done pulse is produced. On the clk edge where areset is sampled high, tx=1 and state=IDLE.
- If areset and a handshake occur in the same cycle, reset wins and the word is not accepted.
- Counter widths: $clog2(OVERSAMPLE) for the tick counter, $clog2(max(DATA_BITS,STOP_BITS)) for the bit counter. No overflow is reachable.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, START, DATA, PARITY, STOP)
  - OVERSAMPLE default constant
  - parity-mode constants (PAR_EVEN, PAR_ODD)
- One natural sub-module, uart_bit_timer: the tick counter.
  - Inputs: clk, areset, clear, s_tick.
  - Output: bit_end pulse on the tick where count==OVERSAMPLE-1.
  - uart_tx_ctrl holds the FSM, shift register and bit counter.

Test Plan:
1. 8N1, s_tick every 4 clk, send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1 with each bit 64 clk (the start bit may be ≤4 clk short); tx_done pulses once; tx_ready returns to 1 the next clk.
2. PARITY_EN=1, even parity, send 0x07 -> parity bit 1. With PARITY_ODD=1, send 0x07 -> parity bit 0. The stop bit follows at 1.
3. tx_valid held high with 0x11 then 0x22 -> 0x22 is accepted only after tx_done plus one IDLE cycle; tx_ready=0 throughout frame 1; both frames are correct on tx.
4. Assert areset for 1 clk during data bit 3 of 0x5A -> tx=1 and tx_ready=1 after that edge; no tx_done; a subsequent 0xFF frame is correct.
5. STOP_BITS=2, send 0x00 -> 8 zero data bits, then tx high for 2 bit periods before tx_done.
6. s_tick held low for 100 clk mid-DATA -> tx and state frozen; the frame resumes and completes correctly when ticks restart.
